// File: rtl/abs_diff_sweep_checker_if.sv
// Operand link (checker -> DUT) and result link (DUT -> checker) of the sweep checker.
// master = checker side, slave = approximate-circuit side.
interface abs_diff_sweep_checker_if #(
    parameter int W  = 2,
    parameter int OW = 3
);
    logic          vec_valid;
    logic          vec_ready;
    logic [W-1:0]  vec_a;
    logic [W-1:0]  vec_b;
    logic          res_valid;
    logic          res_ready;
    logic [OW-1:0] res_data;

    modport master (
        output vec_valid, vec_a, vec_b, res_ready,
        input  vec_ready, res_valid, res_data
    );

    modport slave (
        input  vec_valid, vec_a, vec_b, res_ready,
        output vec_ready, res_valid, res_data
    );
endinterface

// File: rtl/abs_diff_sweep_checker.sv
// Exhaustive {a,b} sweep driver scoring an approximate |a-b| DUT against threshold ET (ABS_DIFF_SWEEP_FIRST_FAIL_EN adds first-fail capture).
// Latency: one vector outstanding; statistics registered one cycle after each result accept.
// Backpressure: vec_a/vec_b/vec_valid held until vec_ready; res_ready only while awaiting a result.
module abs_diff_sweep_checker #(
    parameter int W     = 2,
    parameter int OW    = 3,
    parameter int ET    = 4,
    parameter int CNT_W = 2*W+1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    abs_diff_sweep_checker_if.master link,
    output logic                  busy,
    output logic                  done,
    output logic [OW:0]           max_err,
    output logic [CNT_W-1:0]      viol_cnt,
    output logic [CNT_W+OW-1:0]   err_sum,
    output logic                  pass
`ifdef ABS_DIFF_SWEEP_FIRST_FAIL_EN
    ,
    output logic                  ff_valid,
    output logic [W-1:0]          ff_a,
    output logic [W-1:0]          ff_b,
    output logic [OW-1:0]         ff_res
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2*W-1:0] LAST_IDX = '1;

    state_t          state;
    logic [2*W-1:0]  idx;
    logic            vec_valid_q;
    logic            res_ready_q;

    logic [W-1:0]       a_cur;
    logic [W-1:0]       b_cur;
    logic [W-1:0]       abs_ab;
    logic [OW:0]        exact;
    logic signed [OW+1:0] delta;
    logic signed [OW+1:0] delta_mag;
    logic [OW:0]        err;
    logic               viol_hit;
    logic [CNT_W+OW-1:0] err_sum_nxt;
    logic [CNT_W-1:0]   viol_cnt_nxt;
    logic [OW:0]        max_err_nxt;
    logic               accept;
    logic               start_take;

    // The sweep index is the operand pair itself: b in the LSBs advances first.
    assign a_cur = idx[2*W-1:W];
    assign b_cur = idx[W-1:0];

    assign link.vec_valid = vec_valid_q;
    assign link.vec_a     = a_cur;
    assign link.vec_b     = b_cur;
    assign link.res_ready = res_ready_q;

    assign accept     = (state == S_WAIT) && link.res_valid && res_ready_q;
    assign start_take = start && ((state == S_IDLE) || (state == S_DONE));

    always_comb begin
        abs_ab       = (a_cur >= b_cur) ? (a_cur - b_cur) : (b_cur - a_cur);
        exact        = (OW+1)'(abs_ab);
        // One extra sign bit lets res_data - exact go negative without wrapping.
        delta        = $signed({2'b00, link.res_data}) - $signed({1'b0, exact});
        delta_mag    = delta[OW+1] ? -delta : delta;
        err          = delta_mag[OW:0];
        viol_hit     = int'(err) > ET;
        err_sum_nxt  = err_sum + (CNT_W+OW)'(err);
        viol_cnt_nxt = viol_cnt + (viol_hit ? CNT_W'(1) : '0);
        max_err_nxt  = (err > max_err) ? err : max_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            idx         <= '0;
            vec_valid_q <= 1'b0;
            res_ready_q <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            max_err     <= '0;
            viol_cnt    <= '0;
            err_sum     <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_ISSUE;
                        idx         <= '0;
                        vec_valid_q <= 1'b1;
                        res_ready_q <= 1'b0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        max_err     <= '0;
                        viol_cnt    <= '0;
                        err_sum     <= '0;
                    end
                end
                S_ISSUE: begin
                    if (vec_valid_q && link.vec_ready) begin
                        state       <= S_WAIT;
                        vec_valid_q <= 1'b0;
                        res_ready_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (accept) begin
                        err_sum     <= err_sum_nxt;
                        viol_cnt    <= viol_cnt_nxt;
                        max_err     <= max_err_nxt;
                        res_ready_q <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (viol_cnt_nxt == '0);
                        end else begin
                            state       <= S_ISSUE;
                            idx         <= idx + (2*W)'(1);
                            vec_valid_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    vec_valid_q <= 1'b0;
                    res_ready_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef ABS_DIFF_SWEEP_FIRST_FAIL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_valid <= 1'b0;
            ff_a     <= '0;
            ff_b     <= '0;
            ff_res   <= '0;
        end else if (start_take) begin
            ff_valid <= 1'b0;
            ff_a     <= '0;
            ff_b     <= '0;
            ff_res   <= '0;
        end else if (accept && viol_hit && !ff_valid) begin
            ff_valid <= 1'b1;
            ff_a     <= a_cur;
            ff_b     <= b_cur;
            ff_res   <= link.res_data;
        end
    end
`else
    logic unused_start_take;
    assign unused_start_take = start_take;
`endif

endmodule

// File: tb/tb_abs_diff_sweep_checker.sv
// Scoreboard bench: a behavioural DUT responder feeds results, a negedge monitor checks vectors and statistics.
module tb_abs_diff_sweep_checker;
    localparam int W     = 2;
    localparam int OW    = 3;
    localparam int ET    = 4;
    localparam int CNT_W = 2*W+1;
    localparam int NV    = 1 << (2*W);

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    always #5 clk = ~clk;

    abs_diff_sweep_checker_if #(.W(W), .OW(OW)) link ();

    logic                busy, done, pass;
    logic [OW:0]         max_err;
    logic [CNT_W-1:0]    viol_cnt;
    logic [CNT_W+OW-1:0] err_sum;
`ifdef ABS_DIFF_SWEEP_FIRST_FAIL_EN
    logic                ff_valid;
    logic [W-1:0]        ff_a, ff_b;
    logic [OW-1:0]       ff_res;
`endif

    abs_diff_sweep_checker #(.W(W), .OW(OW), .ET(ET), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .link     (link),
        .busy     (busy),
        .done     (done),
        .max_err  (max_err),
        .viol_cnt (viol_cnt),
        .err_sum  (err_sum),
        .pass     (pass)
`ifdef ABS_DIFF_SWEEP_FIRST_FAIL_EN
        ,
        .ff_valid (ff_valid),
        .ff_a     (ff_a),
        .ff_b     (ff_b),
        .ff_res   (ff_res)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int     mx;
        int     viol;
        int     sum;
        int     ps;
        longint cyc;
        int     ffv;
        int     ffa;
        int     ffb;
        int     ffr;
    } stats_t;

    int     exp_vec[$];
    stats_t exp_stats[$];
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder knobs: 0 exact, 1 const 0, 2 const 7, 3 random result.
    int mode = 0;
    bit rand_ready = 0;
    bit stall3 = 0;
    int stall_cyc = 0;
    bit inject_spur = 0;

    // Monitor-sampled handshakes, consumed by the responder after the next edge.
    bit nf_vec = 0, nf_res = 0;
    int cur_a = 0, cur_b = 0;

    // Reference model state for the current sweep.
    int m_cnt = 0, m_max = 0, m_viol = 0, m_sum = 0;
    int m_ffv = 0, m_ffa = 0, m_ffb = 0, m_ffr = 0;

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic model_clear();
        m_cnt = 0; m_max = 0; m_viol = 0; m_sum = 0;
        m_ffv = 0; m_ffa = 0; m_ffb = 0; m_ffr = 0;
    endtask

    // Behavioural DUT: accepts a pair, answers after a delay, drops everything on reset.
    initial begin : responder
        bit pending;
        int delay;
        int resp;
        bit spur_on;
        pending = 0; delay = 0; resp = 0; spur_on = 0;
        link.vec_ready = 1'b0;
        link.res_valid = 1'b0;
        link.res_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                link.res_valid = 1'b0;
                link.vec_ready = 1'b0;
                pending = 0;
                spur_on = 0;
            end else begin
                if (nf_res) begin
                    link.res_valid = 1'b0;
                    pending = 0;
                end
                if (nf_vec) begin
                    case (mode)
                        0:       resp = iabs(cur_a - cur_b);
                        1:       resp = 0;
                        2:       resp = 7;
                        default: resp = $urandom_range(0, 7);
                    endcase
                    delay   = stall3 ? 4 : (rand_ready ? $urandom_range(0, 3) : 0);
                    pending = 1;
                end
                if (spur_on) begin
                    link.res_valid = 1'b0;
                    spur_on = 0;
                end else if (inject_spur && !pending) begin
                    link.res_valid = 1'b1;
                    link.res_data  = 3'd7;
                    inject_spur = 0;
                    spur_on = 1;
                end
                if (pending && !link.res_valid) begin
                    if (delay == 0) begin
                        link.res_valid = 1'b1;
                        link.res_data  = OW'(resp);
                    end else begin
                        delay--;
                    end
                end
                if (stall3 && link.vec_valid && link.vec_a == 2'd0 && link.vec_b == 2'd3 && stall_cyc < 5) begin
                    link.vec_ready = 1'b0;
                    stall_cyc++;
                end else begin
                    link.vec_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
            end
        end
    end

    // Monitor / scoreboard.
    initial begin : monitor
        bit hold_prev, chk_run, done_prev;
        int ha, hb, ex, er;
        stats_t s;
        hold_prev = 0; chk_run = 0; done_prev = 0; ha = 0; hb = 0;
        forever begin
            @(negedge clk);
            nf_vec = rst_n && link.vec_valid && link.vec_ready;
            nf_res = rst_n && link.res_valid && link.res_ready;
            if (rst_n && chk_run) begin
                check("run_err_sum", err_sum, m_sum);
                check("run_viol_cnt", viol_cnt, m_viol);
                check("run_max_err", max_err, m_max);
            end
            chk_run = 0;
            if (rst_n && hold_prev) begin
                check("hold_valid", link.vec_valid, 1);
                check("hold_a", link.vec_a, ha);
                check("hold_b", link.vec_b, hb);
            end
            hold_prev = rst_n && link.vec_valid && !link.vec_ready;
            ha = link.vec_a;
            hb = link.vec_b;
            if (nf_vec) begin
                if (exp_vec.size() == 0) begin
                    check("extra_vector", 1, 0);
                end else begin
                    ex = exp_vec.pop_front();
                    check("vec_a", link.vec_a, ex / (1 << W));
                    check("vec_b", link.vec_b, ex % (1 << W));
                end
                cur_a = link.vec_a;
                cur_b = link.vec_b;
            end
            if (nf_res) begin
                er = iabs(int'(link.res_data) - iabs(cur_a - cur_b));
                m_cnt++;
                m_sum += er;
                if (er > m_max) m_max = er;
                if (er > ET) begin
                    m_viol++;
                    if (m_ffv == 0) begin
                        m_ffv = 1; m_ffa = cur_a; m_ffb = cur_b; m_ffr = link.res_data;
                    end
                end
                chk_run = 1;
                if (m_cnt == NV) begin
                    s.mx = m_max; s.viol = m_viol; s.sum = m_sum; s.ps = (m_viol == 0);
                    s.cyc = cyc + 1;
                    s.ffv = m_ffv; s.ffa = m_ffa; s.ffb = m_ffb; s.ffr = m_ffr;
                    exp_stats.push_back(s);
                end
            end
            if (rst_n && done && !done_prev) begin
                if (exp_stats.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    s = exp_stats.pop_front();
                    check("done_cycle", cyc, s.cyc);
                    check("max_err", max_err, s.mx);
                    check("viol_cnt", viol_cnt, s.viol);
                    check("err_sum", err_sum, s.sum);
                    check("pass", pass, s.ps);
                    check("busy_at_done", busy, 0);
`ifdef ABS_DIFF_SWEEP_FIRST_FAIL_EN
                    check("ff_valid", ff_valid, s.ffv);
                    check("ff_a", ff_a, s.ffa);
                    check("ff_b", ff_b, s.ffb);
                    check("ff_res", ff_res, s.ffr);
`endif
                end
            end
            done_prev = rst_n && done;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_max_err"}, max_err, 0);
        check({tag, "_viol_cnt"}, viol_cnt, 0);
        check({tag, "_err_sum"}, err_sum, 0);
        check({tag, "_vec_valid"}, link.vec_valid, 0);
        check({tag, "_res_ready"}, link.res_ready, 0);
        check({tag, "_vec_ab"}, {link.vec_a, link.vec_b}, 0);
    endtask

    task automatic start_sweep();
        model_clear();
        exp_vec.delete();
        for (int i = 0; i < NV; i++) exp_vec.push_back(i);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("start_busy", busy, 1);
        check("start_done", done, 0);
        check("start_err_sum", err_sum, 0);
        check("start_viol_cnt", viol_cnt, 0);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!done) check({name, "_timeout"}, 0, 1);
        repeat (2) @(negedge clk);
        check({name, "_vectors_left"}, exp_vec.size(), 0);
    endtask

    task automatic wait_vectors(input int k);
        int n;
        n = 0;
        while (exp_vec.size() > NV - k && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (exp_vec.size() > NV - k) check("wait_vectors_timeout", 0, 1);
    endtask

    initial begin : stimulus
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        mode = 0; rand_ready = 0; start_sweep(); wait_done("exact");
        mode = 1; start_sweep(); wait_done("const0");
        mode = 2; start_sweep(); wait_done("const7");
        mode = 0; stall3 = 1; stall_cyc = 0; start_sweep(); wait_done("stall");
        stall3 = 0;

        // Abort mid-sweep, then spurious result in IDLE, then a clean restart.
        mode = 3; rand_ready = 1; start_sweep(); wait_vectors(10);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("abort");
        exp_vec.delete();
        exp_stats.delete();
        model_clear();
        @(posedge clk); #1 rst_n = 1'b1;
        inject_spur = 1;
        repeat (5) @(negedge clk);
        check_all_zero("spurious");
        mode = 0; start_sweep(); wait_done("restart");

        // start while busy is ignored.
        mode = 3; start_sweep(); wait_vectors(5);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done("busy_start");

        for (int r = 0; r < 3; r++) begin
            start_sweep();
            wait_done("random");
        end

        repeat (3) @(negedge clk);
        check("stats_left", exp_stats.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end
endmodule
